// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller.
// Steps one shared hex decoder across NUM_DIGITS digits, inserting a blanking gap
// at the start of every digit slot. Host frames are staged and committed to the
// displayed (shadow) frame only at frame boundaries. Optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lzb_en,
    output logic [3:0]                num,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      dp,
    output logic                      frame_done,
    output logic                      pending
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CntW-1:0] CntMax   = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] CntShow  = CntW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0] IdxMax   = IdxW'(NUM_DIGITS - 1);

    typedef enum logic {
        StBlank,
        StShow
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] staged_q, staged_d;
    logic [NUM_DIGITS-1:0]   staged_dp_q, staged_dp_d;
    logic                    pending_q, pending_d;
    logic [3:0]              num_q, num_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic slot_wrap;
    logic frame_last;
    logic upper_zero;
    logic lz_blank;

    // Slot counter, digit index and blank/show state machine
    always_comb begin
        slot_wrap  = (cnt_q == CntMax);
        frame_last = slot_wrap && (idx_q == IdxMax);

        cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;

        idx_d = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            StBlank: if (cnt_d == CntShow) state_d = StShow;
            StShow:  if (slot_wrap)        state_d = StBlank;
            default:                       state_d = StBlank;
        endcase
    end

    // Double-buffered frame: stage on load, commit on the frame's last cycle.
    // A load coinciding with the commit bypasses staging and lands in shadow directly.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        staged_d    = staged_q;
        staged_dp_d = staged_dp_q;
        pending_d   = pending_q;

        if (frame_last) begin
            if (load) begin
                shadow_d    = value;
                shadow_dp_d = dp_in;
                staged_d    = value;
                staged_dp_d = dp_in;
            end else if (pending_q) begin
                shadow_d    = staged_q;
                shadow_dp_d = staged_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            staged_d    = value;
            staged_dp_d = dp_in;
            pending_d   = 1'b1;
        end
    end

    // Registered outputs, computed from the next-cycle scan position so each
    // output register reflects the state of the cycle it is visible in
    always_comb begin
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx_d) && shadow_d[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        lz_blank = lzb_en && (idx_d != '0) && upper_zero;

        // num only moves during BLANK so it settles before the enable rises
        num_d = num_q;
        if (state_d == StBlank) begin
            num_d = shadow_d[{idx_d, 2'b00} +: 4];
        end

        digit_en_d = '0;
        dp_d       = 1'b0;
        if (state_d == StShow && !lz_blank) begin
            digit_en_d[idx_d] = 1'b1;
            dp_d              = shadow_dp_d[idx_d];
        end

        frame_done_d = (cnt_d == CntMax) && (idx_d == IdxMax);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            staged_q     <= '0;
            staged_dp_q  <= '0;
            pending_q    <= 1'b0;
            num_q        <= 4'h0;
            digit_en_q   <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            staged_q     <= staged_d;
            staged_dp_q  <= staged_dp_d;
            pending_q    <= pending_d;
            num_q        <= num_d;
            digit_en_q   <= digit_en_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign num        = num_q;
    assign digit_en   = digit_en_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
// A timeline model (cycles since reset, frame-level commit) predicts every output.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * P;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value = 16'h0;
    logic [3:0]    dp_in = 4'h0;
    logic          lzb_en = 1'b0;
    logic [3:0]    num;
    logic [3:0]    digit_en;
    logic          dp;
    logic          frame_done;
    logic          pending;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (N),
        .PRESCALE    (P),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .lzb_en    (lzb_en),
        .num       (num),
        .digit_en  (digit_en),
        .dp        (dp),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset plus displayed/staged frames
    int          m_t = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_shadow = 16'h0, m_staged = 16'h0;
    logic [3:0]  m_sdp = 4'h0, m_stdp = 4'h0;
    logic        m_pend = 1'b0;
    logic        m_lzb = 1'b0;

    always @(posedge clk) begin
        m_lzb <= lzb_en;
        if (rst) begin
            m_valid  <= 1'b1;
            m_t      <= 0;
            m_shadow <= 16'h0;
            m_sdp    <= 4'h0;
            m_staged <= 16'h0;
            m_stdp   <= 4'h0;
            m_pend   <= 1'b0;
        end else begin
            m_t <= m_t + 1;
            if (m_t % FRAME == FRAME - 1) begin
                if (load) begin
                    m_shadow <= value;
                    m_sdp    <= dp_in;
                end else if (m_pend) begin
                    m_shadow <= m_staged;
                    m_sdp    <= m_stdp;
                end
                m_pend <= 1'b0;
            end else if (load) begin
                m_staged <= value;
                m_stdp   <= dp_in;
                m_pend   <= 1'b1;
            end
        end
    end

    // Continuous comparison against the model on every falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            int   s, c;
            logic zeros, blank;
            logic [3:0] e_en;
            s = (m_t / P) % N;
            c = m_t % P;
            zeros = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (i >= s && m_shadow[4*i +: 4] != 4'h0) zeros = 1'b0;
            end
            blank = m_lzb && (s != 0) && zeros;
            e_en  = (c >= B && !blank) ? (4'b0001 << s) : 4'b0000;
            check("model_num", 32'(num), 32'(m_shadow[4*s +: 4]));
            check("model_digit_en", 32'(digit_en), 32'(e_en));
            check("model_dp", 32'(dp), 32'((c >= B && !blank) ? m_sdp[s] : 1'b0));
            check("model_frame_done", 32'(frame_done),
                  32'((s == N - 1) && (c == P - 1)));
            check("model_pending", 32'(pending), 32'(m_pend));
            check("onehot", 32'($countones(digit_en) <= 1), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto_cycle(input int t);
        while (m_t < t) @(negedge clk);
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_timeout", 32'(frame_done), 32'd1);
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
        logic [3:0]  en;   // digits expected visible
        logic [3:0]  dpx;  // digits expected to light dp
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111, 4'b0000};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, 4'b0000};
        vecs[3] = '{16'h0000, 4'b0000, 1'b0, 4'b1111, 4'b0000};
        vecs[4] = '{16'h0000, 4'b0100, 1'b0, 4'b1111, 4'b0100};
        vecs[5] = '{16'h0500, 4'b0000, 1'b1, 4'b0111, 4'b0000};
        vecs[6] = '{16'hF00F, 4'b1001, 1'b1, 4'b1111, 4'b1001};
        vecs[7] = '{16'h00A0, 4'b1010, 1'b1, 4'b0011, 4'b0010};

        // Reset and scenario 1: first load, commit at cycle 31
        step(3);
        check("rst_num", 32'(num), 32'd0);
        check("rst_digit_en", 32'(digit_en), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        goto_cycle(3);
        load = 1'b1; value = 16'h1234; dp_in = 4'h0;
        step(1);
        load = 1'b0;
        check("s1_pending_c4", 32'(pending), 32'd1);
        goto_cycle(31);
        check("s1_fd_c31", 32'(frame_done), 32'd1);
        check("s1_pending_c31", 32'(pending), 32'd1);
        goto_cycle(32);
        check("s1_pending_c32", 32'(pending), 32'd0);
        check("s1_num_c32", 32'(num), 32'd4);
        check("s1_en_c32", 32'(digit_en), 32'd0);
        goto_cycle(34);
        check("s1_num_c34", 32'(num), 32'd4);
        check("s1_en_c34", 32'(digit_en), 32'b0001);
        goto_cycle(39);
        check("s1_en_c39", 32'(digit_en), 32'b0001);
        goto_cycle(40);
        check("s1_en_c40", 32'(digit_en), 32'd0);
        check("s1_num_c40", 32'(num), 32'd3);
        goto_cycle(42);
        check("s1_num_c42", 32'(num), 32'd3);
        check("s1_en_c42", 32'(digit_en), 32'b0010);

        // Table-driven frames: load, wait for commit, sample each digit's SHOW
        foreach (vecs[k]) begin
            load = 1'b1; value = vecs[k].value; dp_in = vecs[k].dp; lzb_en = vecs[k].lzb;
            step(1);
            load = 1'b0;
            wait_fd();
            step(1 + B);
            for (int s = 0; s < N; s++) begin
                logic [15:0] v;
                v = vecs[k].value;
                check($sformatf("vec%0d_d%0d_en", k, s), 32'(digit_en),
                      32'(vecs[k].en[s] ? (4'b0001 << s) : 4'b0000));
                check($sformatf("vec%0d_d%0d_num", k, s), 32'(num), 32'(v[4*s +: 4]));
                check($sformatf("vec%0d_d%0d_dp", k, s), 32'(dp), 32'(vecs[k].dpx[s]));
                step(P);
            end
        end
        lzb_en = 1'b0;

        // Load on the frame_done cycle overrides an earlier staged frame
        wait_fd();
        step(6);
        load = 1'b1; value = 16'hAAAA; dp_in = 4'h0;
        step(1);
        load = 1'b0;
        wait_fd();
        load = 1'b1; value = 16'hBBBB;
        step(1);
        load = 1'b0;
        check("coll_pending", 32'(pending), 32'd0);
        check("coll_num", 32'(num), 32'hB);

        // Two loads before commit: the later one wins
        step(5);
        load = 1'b1; value = 16'h1111;
        step(1);
        load = 1'b0;
        step(3);
        load = 1'b1; value = 16'h2222;
        step(1);
        load = 1'b0;
        wait_fd();
        step(1);
        check("twoload_num", 32'(num), 32'h2);
        check("twoload_pending", 32'(pending), 32'd0);

        // Reset during digit 2 SHOW with a staged frame pending
        load = 1'b1; value = 16'h9999;
        step(1);
        load = 1'b0;
        check("rstmid_pending_before", 32'(pending), 32'd1);
        step(19);
        check("rstmid_in_show", 32'(digit_en), 32'b0100);
        rst = 1'b1;
        step(1);
        check("rstmid_en", 32'(digit_en), 32'd0);
        check("rstmid_num", 32'(num), 32'd0);
        check("rstmid_pending", 32'(pending), 32'd0);
        check("rstmid_fd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        wait_fd();
        step(1 + B);
        check("rstmid_discard_num", 32'(num), 32'd0);
        check("rstmid_restart_en", 32'(digit_en), 32'b0001);

        // Randomized traffic checked by the model
        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 11) == 0);
            value = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 79) == 0) lzb_en = ~lzb_en;
            step(1);
        end
        load = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode/cathode 7-segment display driven through a single shared 7-segment hex decoder.
- Holds a frame of hex nibbles and steps the shared decoder through the digits one slot at a time.
- Drives the per-digit enables, with a blanking gap between digits to prevent ghosting.
- Display updates are double-buffered and committed only at frame boundaries, plus optional leading-zero blanking.
- Sits between the host logic that produces display values and the decoder/pad drivers.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2); digit NUM_DIGITS-1 is most significant
PRESCALE, 50000, clock cycles per digit slot (blank + show); must exceed BLANK_CYCLES
BLANK_CYCLES, 16, cycles at the start of each slot with all digit enables low (>=1)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
load  input  1  one-cycle request to stage a new display frame
value  input  4*NUM_DIGITS  nibble i = bits [4i+3:4i] = hex value for digit i
dp_in  input  NUM_DIGITS  decimal-point request per digit, sampled with load
lzb_en  input  1  leading-zero blanking enable (level, sampled every cycle)
num  output  4  hex code to the shared decoder's num input (registered)
digit_en  output  NUM_DIGITS  active-high one-hot digit enable (registered)
dp  output  1  decimal point for the currently enabled digit (registered)
frame_done  output  1  one-cycle pulse on the last cycle of each frame
pending  output  1  high while a loaded frame is waiting for commit

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst high at a clock edge) clears all of the following, regardless of the current slot or a pending frame:
  - Outputs: num=0, digit_en=0, dp=0, frame_done=0, pending=0.
  - Shadow frame, staged frame and staged decimal points cleared to 0.
  - Digit index idx=0, slot counter cnt=0, state=BLANK.
- Slot counter:
  - cnt runs 0..PRESCALE-1, then wraps to 0.
  - On wrap, idx increments; NUM_DIGITS-1 wraps to 0.
- State machine, two states:
  - BLANK while cnt < BLANK_CYCLES; SHOW for the remaining cycles of the slot.
  - BLANK -> SHOW when cnt reaches BLANK_CYCLES.
  - SHOW -> BLANK on slot wrap.
- Outputs in BLANK:
  - digit_en=0, dp=0.
  - num = shadow nibble idx, registered, so it is stable at least BLANK_CYCLES before the enable rises.
- Outputs in SHOW:
  - digit_en = one-hot(idx), unless the digit is leading-zero blanked.
  - dp = shadow dp bit idx.
  - num is held.
- Leading-zero blanking:
  - Applies when lzb_en=1, idx != 0, and shadow nibbles idx..NUM_DIGITS-1 are all zero.
  - Effect: digit_en stays 0 for that whole slot and dp=0.
  - Digit 0 is never blanked, so an all-zero value shows "0".
- Staging:
  - load=1 captures value and dp_in into the staged registers and sets pending=1.
  - Repeated loads before commit overwrite; the latest wins.
- Commit:
  - On the frame's last cycle (idx=NUM_DIGITS-1, cnt=PRESCALE-1), frame_done=1 for exactly one cycle.
  - If pending=1, shadow <= staged frame and pending clears at the same edge.
  - If load=1 on that same cycle, the load-bus values commit directly to shadow and pending ends at 0.
- Latency: a committed frame first appears on num at the first cycle of the next frame (digit 0, BLANK).
- Frame period: exactly NUM_DIGITS*PRESCALE cycles.
- No output ever has more than one digit_en bit set.
- digit_en never rises in the same cycle that num changes.

Test Plan:
(All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.)
1. Reset, then load value=16'h1234, dp_in=0 at cycle 3:
   - pending=1 until the first frame_done (cycle 31); pending=0 from cycle 32.
   - From cycle 32: num=4 with digit_en=0001 during cycles 34-39, then num=3 with digit_en=0010 during cycles 42-47, and so on.
2. Steady frame:
   - digit_en is 0 for 2 cycles at every slot start.
   - frame_done pulses every 32 cycles.
   - num never changes while digit_en != 0.
3. lzb_en=1, committed value=16'h0050:
   - Digits 3 and 2 have digit_en=0 for their whole slots.
   - Digits 1 and 0 show 5 and 0.
   - value=16'h0000 shows only digit 0 with num=0.
4. Boundary collisions:
   - load 16'hAAAA mid-frame, then load 16'hBBBB on the frame_done cycle: shadow=16'hBBBB next frame, pending=0.
   - Two loads mid-frame (16'h1111 then 16'h2222): 16'h2222 commits.
5. rst asserted mid-SHOW of digit 2 with pending=1:
   - The next cycle has digit_en=0, num=0, pending=0, frame_done=0.
   - Scan restarts at digit 0 BLANK; the staged frame is discarded.
6. dp_in=4'b0100 committed:
   - dp=1 only during digit 2's SHOW cycles.
   - dp=0 during BLANK and all other digits.
